// File: rtl/ecdsa_verify_arbiter_pkg.sv
// Shared ECDSA operand and response types, plus the arbiter FSM encoding.
package elliptic_curve_structs;

    localparam int COORD_W = 96;

    typedef struct packed {
        logic [COORD_W-1:0] r;
        logic [COORD_W-1:0] s;
    } signature_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    typedef struct packed {
        logic invalid;
        logic timeout;
    } verify_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ecdsa_verify_arbiter_rr.sv
// Combinational round-robin picker: first request searching upward from i_last+1.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    input  logic          i_en,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int k = 1; k <= N; k++) begin
            // One extra bit so last+k cannot overflow before the wrap.
            w_sum = {1'b0, i_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_j = w_sum[IW-1:0];
            if (i_en && !w_found && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecdsa_verify_arbiter.sv
// Round-robin front end sharing one ECDSA verify engine between NUM_REQ requesters,
// with operand latching, start pulse, done/timeout tracking and per-requester response.
module ecdsa_verify_arbiter
    import elliptic_curve_structs::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MSG_SIZE       = 96,
    parameter int TIMEOUT_CYCLES = 2**20,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  signature_t   [NUM_REQ-1:0]         req_signature,
    input  logic [NUM_REQ-1:0][MSG_SIZE-1:0]   req_message,
    input  curve_point_t [NUM_REQ-1:0]         req_pub_key,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic                               rsp_invalid,
    output logic                               rsp_timeout,
    output logic                               eng_init,
    output signature_t                         eng_signature,
    output logic [MSG_SIZE-1:0]                eng_message,
    output curve_point_t                       eng_pub_key,
    output logic                               eng_abort,
    input  logic                               eng_done,
    input  logic                               eng_invalid,
    output logic                               busy,
    output logic [IW-1:0]                      cur_grant
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic [IW-1:0]       r_last_grant;
    logic [IW-1:0]       r_cur_grant;
    signature_t          r_eng_sig;
    logic [MSG_SIZE-1:0] r_eng_msg;
    curve_point_t        r_eng_key;
    logic [CNT_W-1:0]    r_cnt;
    verify_rsp_t         r_rsp;
    logic                r_eng_init;
    logic                r_eng_abort;
    logic                r_busy;
    logic [NUM_REQ-1:0]  r_rsp_valid;

    logic                w_arb_en;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_accept;
    logic                w_cnt_hit;

    // Gating with reset keeps req_ready low while the block is held in reset.
    assign w_arb_en  = (r_state == ST_IDLE) && reset;
    assign w_accept  = |w_grant;
    assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_START;
            ST_START: w_next = ST_BUSY;
            ST_BUSY:  if (eng_done || w_cnt_hit) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= IW'(NUM_REQ - 1);
            r_cur_grant  <= '0;
            r_eng_sig    <= '0;
            r_eng_msg    <= '0;
            r_eng_key    <= '0;
            r_cnt        <= '0;
            r_rsp        <= '0;
            r_eng_init   <= 1'b0;
            r_eng_abort  <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_valid  <= '0;
        end else begin
            r_eng_init  <= (r_state == ST_IDLE) && w_accept;
            r_busy      <= (w_next != ST_IDLE);
            r_eng_abort <= 1'b0;
            r_rsp_valid <= '0;
            if ((r_state == ST_IDLE) && w_accept) begin
                r_eng_sig    <= req_signature[w_idx];
                r_eng_msg    <= req_message[w_idx];
                r_eng_key    <= req_pub_key[w_idx];
                r_last_grant <= w_idx;
                r_cur_grant  <= w_idx;
            end
            // Any done level seen during START belongs to the previous job.
            if (r_state == ST_START) begin
                r_cnt <= '0;
                r_rsp <= '0;
            end
            if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (eng_done) begin
                    r_rsp.invalid <= eng_invalid;
                    r_rsp.timeout <= 1'b0;
                    r_rsp_valid   <= NUM_REQ'(1) << r_cur_grant;
                end else if (w_cnt_hit) begin
                    r_rsp.invalid <= 1'b1;
                    r_rsp.timeout <= 1'b1;
                    r_rsp_valid   <= NUM_REQ'(1) << r_cur_grant;
                    r_eng_abort   <= 1'b1;
                end
            end
        end
    end

    assign req_ready     = w_grant;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_invalid   = r_rsp.invalid;
    assign rsp_timeout   = r_rsp.timeout;
    assign eng_init      = r_eng_init;
    assign eng_signature = r_eng_sig;
    assign eng_message   = r_eng_msg;
    assign eng_pub_key   = r_eng_key;
    assign eng_abort     = r_eng_abort;
    assign busy          = r_busy;
    assign cur_grant     = r_cur_grant;

endmodule

// File: tb/tb_ecdsa_verify_arbiter.sv
// Scoreboard bench for ecdsa_verify_arbiter: directed requests, a small engine model,
// and a monitor that checks grants, operands and responses as they appear.
module tb_ecdsa_verify_arbiter;
    import elliptic_curve_structs::*;

    localparam int NR = 4;
    localparam int MW = 96;
    localparam int TC = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NR-1:0]          req_valid = '0;
    signature_t   [NR-1:0]  req_signature;
    logic [NR-1:0][MW-1:0]  req_message;
    curve_point_t [NR-1:0]  req_pub_key;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0]          rsp_valid;
    logic                   rsp_invalid;
    logic                   rsp_timeout;
    logic                   eng_init;
    signature_t             eng_signature;
    logic [MW-1:0]          eng_message;
    curve_point_t           eng_pub_key;
    logic                   eng_abort;
    logic                   eng_done = 1'b0;
    logic                   eng_invalid = 1'b0;
    logic                   busy;
    logic [1:0]             cur_grant;

    ecdsa_verify_arbiter #(.NUM_REQ(NR), .MSG_SIZE(MW), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_signature(req_signature),
        .req_message(req_message), .req_pub_key(req_pub_key), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .eng_init(eng_init), .eng_signature(eng_signature), .eng_message(eng_message),
        .eng_pub_key(eng_pub_key), .eng_abort(eng_abort), .eng_done(eng_done),
        .eng_invalid(eng_invalid), .busy(busy), .cur_grant(cur_grant)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; bit inv; bit tmo; } exp_t;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           grant_q[$];
    exp_t         rsp_q[$];
    logic [NR-1:0] acc_mask = '0;
    int           last_rdy_cyc = 0;
    int           last_init_cyc = 0;
    int           last_rsp_cyc = 0;
    int           eng_lat = 3;
    bit           eng_inv_cfg = 1'b0;
    bit           eng_hold = 1'b0;
    logic [MW-1:0]   msg_tab [NR];
    signature_t      sig_tab [NR];
    curve_point_t    key_tab [NR];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic push(input int idx, input bit inv, input bit tmo, input bit with_rsp);
        exp_t e;
        grant_q.push_back(idx);
        if (with_rsp) begin
            e.idx = idx; e.inv = inv; e.tmo = tmo;
            rsp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick();
        while (!(grant_q.size() == 0 && rsp_q.size() == 0 && req_valid == 0 && busy == 1'b0)
               && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_wait actual=still_pending required=idle", name);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"},    busy, 1'b0);
        chk({name, "_grant"},   cur_grant, 2'd0);
        chk({name, "_init"},    eng_init, 1'b0);
        chk({name, "_abort"},   eng_abort, 1'b0);
        chk({name, "_rspv"},    rsp_valid, 4'b0);
        chk({name, "_ready"},   req_ready, 4'b0);
        chk({name, "_msg"},     eng_message, '0);
        chk({name, "_sig"},     eng_signature, '0);
        chk({name, "_flags"},   {rsp_invalid, rsp_timeout}, 2'b00);
    endtask

    // Tick counter and cycle budget.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Engine model: done (with configured invalid) eng_lat cycles after eng_init.
    initial begin : engine
        int  cnt;
        bit  drop_next;
        bit  fire;
        cnt = 0;
        drop_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                eng_done = 1'b0; eng_invalid = 1'b0; cnt = 0; drop_next = 1'b0;
            end else if (eng_init) begin
                cnt = eng_lat;
                drop_next = 1'b1;
            end else begin
                fire = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    fire = (cnt == 0);
                end
                if (fire) begin
                    eng_done = 1'b1; eng_invalid = eng_inv_cfg;
                end else if (drop_next || !eng_hold) begin
                    eng_done = 1'b0; eng_invalid = 1'b0;
                end
                drop_next = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, start or response.
    initial begin : monitor
        int   gexp;
        int   mon_idx;
        exp_t e;
        mon_idx = 0;
        forever begin
            @(negedge clk);
            acc_mask = req_ready;
            if (req_ready != 0) begin
                last_rdy_cyc = cyc;
                if (grant_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_grant actual=%b required=none", req_ready);
                end else begin
                    gexp = grant_q.pop_front();
                    chk("grant", req_ready, 4'(1) << gexp);
                    mon_idx = gexp;
                end
            end
            if (eng_init) begin
                last_init_cyc = cyc;
                chk("eng_message", eng_message, msg_tab[mon_idx]);
                chk("eng_signature", eng_signature, sig_tab[mon_idx]);
                chk("eng_pub_key", eng_pub_key, key_tab[mon_idx]);
            end
            if (rsp_valid != 0) begin
                last_rsp_cyc = cyc;
                if (rsp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp actual=%b required=none", rsp_valid);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", rsp_valid, 4'(1) << e.idx);
                    chk("rsp_invalid", rsp_invalid, e.inv);
                    chk("rsp_timeout", rsp_timeout, e.tmo);
                    chk("eng_abort", eng_abort, e.tmo);
                end
            end else if (eng_abort) begin
                checks++; failures++;
                $display("FAIL stray_abort actual=1 required=0");
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            msg_tab[i]   = 96'h0123_4567_89AB_CDEF_0000_0000 + 96'(i * 4369 + 7);
            sig_tab[i].r = 96'(32'h1111_0000 + i);
            sig_tab[i].s = 96'(32'h2222_0000 + i) << 40;
            key_tab[i].x = 96'(32'h3333_0000 + i) << 20;
            key_tab[i].y = 96'(32'h4444_0000 + i) << 60;
            req_message[i]   = msg_tab[i];
            req_signature[i] = sig_tab[i];
            req_pub_key[i]   = key_tab[i];
        end

        // Reset state.
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Single request, engine done 10 cycles after start.
        eng_lat = 10; eng_inv_cfg = 1'b0; eng_hold = 1'b0;
        push(0, 1'b0, 1'b0, 1'b1);
        req_valid = 4'b0001;
        wait_idle("single");
        chk("single_init_lat", last_init_cyc - last_rdy_cyc, 1);
        chk("single_rsp_lat", last_rsp_cyc - last_rdy_cyc, 12);

        // All four pending across reset release, then 0 and 2, then 2 alone.
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 4'b1111;
        tick();
        chk("reset_ready_gated", req_ready, 4'b0000);
        chk("reset_grant", cur_grant, 2'd0);
        reset = 1'b1;
        eng_lat = 3;
        for (int i = 0; i < NR; i++) push(i, 1'b0, 1'b0, 1'b1);
        wait_idle("all4");
        chk("all4_rsp_lat", last_rsp_cyc - last_rdy_cyc, 5);
        push(0, 1'b0, 1'b0, 1'b1);
        push(2, 1'b0, 1'b0, 1'b1);
        req_valid = 4'b0101;
        wait_idle("pair02");
        push(2, 1'b0, 1'b0, 1'b1);
        req_valid = 4'b0100;
        wait_idle("regrant2");
        chk("regrant_cur_grant", cur_grant, 2'd2);

        // Invalid signature from requester 1.
        eng_lat = 5; eng_inv_cfg = 1'b1;
        push(1, 1'b1, 1'b0, 1'b1);
        req_valid = 4'b0010;
        wait_idle("invalid");
        eng_inv_cfg = 1'b0;

        // Timeout: engine never answers.
        eng_lat = -1;
        push(3, 1'b1, 1'b1, 1'b1);
        req_valid = 4'b1000;
        wait_idle("timeout");
        chk("timeout_rsp_lat", last_rsp_cyc - last_rdy_cyc, TC + 2);

        // Stale done level held into the next job's START.
        eng_lat = 2; eng_hold = 1'b1;
        push(0, 1'b0, 1'b0, 1'b1);
        req_valid = 4'b0001;
        wait_idle("stale_prev");
        chk("stale_level_high", eng_done, 1'b1);
        eng_lat = 6;
        push(1, 1'b0, 1'b0, 1'b1);
        req_valid = 4'b0010;
        wait_idle("stale");
        chk("stale_rsp_lat", last_rsp_cyc - last_rdy_cyc, 8);
        eng_hold = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of BUSY.
        eng_lat = 20;
        push(2, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0100;
        repeat (6) tick();
        chk("midbusy_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk_reset_outputs("async");
        tick();
        reset = 1'b1;
        eng_lat = 3;
        push(0, 1'b0, 1'b0, 1'b1);
        wait_idle("after_reset");
        repeat (30) tick();
        chk("leftover_grants", grant_q.size(), 0);
        chk("leftover_rsps", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
